// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_buf
// Description : Elastic pipeline buffer with valid/ready handshakes on both
//               sides. Entries sit in a small circular array and leave in
//               FIFO order. Both output-side signals and in_ready_o come from
//               registered state only, so the stage breaks every timing path
//               through the handshake.
//
//               DEPTH=1 gives a single stage register at half throughput.
//               DEPTH>=2 sustains one transfer per cycle.
//
// Ports       : clk_i        rising-edge clock
//               rst_i        synchronous active-high reset (highest priority)
//               flush_i      discard every held entry; drops a same-cycle push
//               in_valid_i   upstream payload valid
//               in_ready_o   buffer can accept (count < DEPTH)
//               in_data_i    upstream payload
//               out_valid_o  head entry valid (count != 0)
//               out_ready_i  downstream accepts the head entry
//               out_data_o   head payload, all-zero while empty
//               count_o      current occupancy, 0..DEPTH
//
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_buf #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DATA_W-1:0]          in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DATA_W-1:0]          out_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    // Pointers need at least one bit, even though DEPTH=1 uses only entry 0.
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    // Kept as its own flop, not decoded from r_count, so out_valid_o comes
    // straight from a register.
    logic               r_out_valid;

    logic               w_in_ready;
    logic               w_push;
    logic               w_pop;
    logic [c_PTR_W-1:0] w_rd_ptr_nxt;
    logic [c_PTR_W-1:0] w_wr_ptr_nxt;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic               w_out_valid_nxt;

    // Advance a pointer around the circular array. A non-power-of-two DEPTH
    // needs the explicit wrap. The natural binary rollover is not enough.
    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] ptr);
        if (ptr == c_PTR_LAST) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    // ------------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------------
    // in_ready_o depends only on the registered count. A pop in the same cycle
    // does not free a slot for a push: when full, the producer waits a cycle.
    assign w_in_ready = (r_count != c_CNT_FULL);
    assign w_push     = in_valid_i & w_in_ready;
    assign w_pop      = r_out_valid & out_ready_i;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_rd_ptr_nxt    = r_rd_ptr;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_count_nxt     = r_count;
        w_out_valid_nxt = r_out_valid;

        if (flush_i) begin
            // Flush beats push and pop. Everything held, plus any
            // same-cycle push, is dropped.
            w_rd_ptr_nxt    = '0;
            w_wr_ptr_nxt    = '0;
            w_count_nxt     = '0;
            w_out_valid_nxt = 1'b0;
        end else begin
            if (w_push) begin
                w_wr_ptr_nxt = f_ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                w_rd_ptr_nxt = f_ptr_inc(r_rd_ptr);
            end

            // A simultaneous push and pop leaves the occupancy unchanged.
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + 1'b1;
                2'b01:   w_count_nxt = r_count - 1'b1;
                default: w_count_nxt = r_count;
            endcase

            w_out_valid_nxt = (w_count_nxt != '0);
        end
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_count     <= w_count_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    // The array is not reset. Stale contents can never reach the output,
    // because out_data_o is masked whenever no entry is held.
    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i && !rst_i) begin
            r_mem[r_wr_ptr] <= in_data_i;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready_o  = w_in_ready;
    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_valid ? r_mem[r_rd_ptr] : '0;
    assign count_o     = r_count;

endmodule
`default_nettype wire
